fwd_scoreboard: RTL and testbench

//  Parametrised register-operand bypass network with an internal in-flight write scoreboard.

---
 rtl/fwd_scoreboard.sv | 90 +++++++++
 tb/tb_fwd_scoreboard.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Operand bypass network with an in-flight write scoreboard: forwards the youngest
// ready result per read port, raises a load-use stall, and counts stall cycles.
module fwd_scoreboard #(
  parameter int XLEN       = 32,
  parameter int REG_AW     = 5,
  parameter int NUM_READ   = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       issue_valid_i,
  input  logic                       issue_we_i,
  input  logic                       issue_load_i,
  input  logic [REG_AW-1:0]          issue_rd_i,
  input  logic [NUM_READ*REG_AW-1:0] rs_addr_i,
  input  logic [NUM_READ-1:0]        rs_used_i,
  input  logic [NUM_READ*XLEN-1:0]   rf_rdata_i,
  input  logic [DEPTH*XLEN-1:0]      stage_data_i,
  input  logic                       hold_i,
  input  logic                       flush_i,
  output logic [NUM_READ*XLEN-1:0]   rdata_o,
  output logic [NUM_READ-1:0]        fwd_hit_o,
  output logic                       stall_o,
  output logic [31:0]                stall_cnt_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  we_q;
  logic [DEPTH-1:0]  load_q;
  logic [REG_AW-1:0] rd_q [DEPTH];

  logic [NUM_READ-1:0] port_found;
  logic [NUM_READ-1:0] port_ready;
  logic [XLEN-1:0]     port_data [NUM_READ];

  // Scan oldest to youngest so the youngest matching entry is the one left standing.
  always_comb begin
    rdata_o    = rf_rdata_i;
    fwd_hit_o  = '0;
    stall_o    = 1'b0;
    port_found = '0;
    port_ready = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      port_data[p] = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (valid_q[k] && we_q[k] && rs_used_i[p] &&
            (rd_q[k] == rs_addr_i[p*REG_AW +: REG_AW]) &&
            (rs_addr_i[p*REG_AW +: REG_AW] != '0)) begin
          port_found[p] = 1'b1;
          port_ready[p] = !load_q[k] || (k >= LOAD_READY);
          port_data[p]  = stage_data_i[k*XLEN +: XLEN];
        end
      end
      if (port_found[p] && port_ready[p]) begin
        rdata_o[p*XLEN +: XLEN] = port_data[p];
        fwd_hit_o[p]            = 1'b1;
      end else if (port_found[p]) begin
        stall_o = 1'b1;
      end
    end
  end

  // A stalled issue enters as a bubble so the consumer is re-presented next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      we_q        <= '0;
      load_q      <= '0;
      stall_cnt_o <= '0;
      for (int k = 0; k < DEPTH; k++) rd_q[k] <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (!hold_i) begin
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1];
        we_q[k]    <= we_q[k-1];
        load_q[k]  <= load_q[k-1];
        rd_q[k]    <= rd_q[k-1];
      end
      valid_q[0] <= issue_valid_i && !stall_o;
      we_q[0]    <= issue_we_i;
      load_q[0]  <= issue_load_i;
      rd_q[0]    <= issue_rd_i;
      if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard with default parameters.
module tb_fwd_scoreboard;

  localparam logic [31:0] RF_A = 32'hAAAA_0000;
  localparam logic [31:0] RF_B = 32'hBBBB_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid_i, issue_we_i, issue_load_i;
  logic [4:0]  issue_rd_i;
  logic [9:0]  rs_addr_i;
  logic [1:0]  rs_used_i;
  logic [63:0] rf_rdata_i;
  logic [95:0] stage_data_i;
  logic        hold_i, flush_i;
  logic [63:0] rdata_o;
  logic [1:0]  fwd_hit_o;
  logic        stall_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  fwd_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid_i), .issue_we_i(issue_we_i),
    .issue_load_i(issue_load_i), .issue_rd_i(issue_rd_i),
    .rs_addr_i(rs_addr_i), .rs_used_i(rs_used_i),
    .rf_rdata_i(rf_rdata_i), .stage_data_i(stage_data_i),
    .hold_i(hold_i), .flush_i(flush_i),
    .rdata_o(rdata_o), .fwd_hit_o(fwd_hit_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic we, input logic ld, input logic [4:0] rd,
                               input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
    issue_valid_i = iv;
    issue_we_i    = we;
    issue_load_i  = ld;
    issue_rd_i    = rd;
    rs_addr_i     = {rs1, rs0};
    rs_used_i     = used;
    #1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00);
    repeat (3) cycle();
  endtask

  initial begin
    rst = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
    rf_rdata_i   = {RF_B, RF_A};
    stage_data_i = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00);

    // T1: reset
    cycle(); cycle();
    rst = 1'b0;
    #1;
    checkOutput("t1_stall", stall_o, 0);
    checkOutput("t1_rdata", rdata_o, {RF_B, RF_A});
    checkOutput("t1_hit", fwd_hit_o, 2'b00);
    checkOutput("t1_cnt", stall_cnt_o, 0);

    // T2: ALU x5 forwarded from stage 0
    applyStimulus(1, 1, 0, 5'd5, 5'd0, 5'd0, 2'b00);
    cycle();
    stage_data_i[31:0] = 32'hDEAD_BEEF;
    applyStimulus(0, 0, 0, 5'd0, 5'd5, 5'd0, 2'b01);
    checkOutput("t2_p0", rdata_o[31:0], 32'hDEAD_BEEF);
    checkOutput("t2_p1", rdata_o[63:32], RF_B);
    checkOutput("t2_hit", fwd_hit_o, 2'b01);
    checkOutput("t2_stall", stall_o, 0);

    // T3: x5 in stage 0 and stage 2, youngest wins on p1
    cycle();
    applyStimulus(1, 1, 0, 5'd5, 5'd0, 5'd0, 2'b00);
    cycle();
    stage_data_i = {32'd3, 32'd2, 32'd1};
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd5, 2'b10);
    checkOutput("t3_p1", rdata_o[63:32], 32'd1);
    checkOutput("t3_p0", rdata_o[31:0], RF_A);
    checkOutput("t3_hit", fwd_hit_o, 2'b10);
    cycle();
    checkOutput("t3_s1_p1", rdata_o[63:32], 32'd2);
    checkOutput("t3_s1_hit", fwd_hit_o, 2'b10);

    // T4: load-use stall for one cycle, bubble inserted
    drain();
    stage_data_i = {32'hC3C3_C3C3, 32'hC2C2_C2C2, 32'hC1C1_C1C1};
    applyStimulus(1, 1, 1, 5'd7, 5'd0, 5'd0, 2'b00);
    cycle();
    applyStimulus(1, 1, 0, 5'd9, 5'd7, 5'd9, 2'b11);
    checkOutput("t4_stall", stall_o, 1);
    checkOutput("t4_hit_stall", fwd_hit_o, 2'b00);
    cycle();
    checkOutput("t4_stall_end", stall_o, 0);
    checkOutput("t4_p0", rdata_o[31:0], 32'hC2C2_C2C2);
    checkOutput("t4_p1_bubble", rdata_o[63:32], RF_B);
    checkOutput("t4_hit", fwd_hit_o, 2'b01);
    checkOutput("t4_cnt", stall_cnt_o, 1);

    // T5: x0 never matches; unused port ignores a pending load
    drain();
    applyStimulus(1, 1, 0, 5'd0, 5'd0, 5'd0, 2'b00);
    cycle();
    applyStimulus(1, 1, 1, 5'd7, 5'd0, 5'd0, 2'b00);
    cycle();
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd7, 2'b01);
    checkOutput("t5_hit", fwd_hit_o, 2'b00);
    checkOutput("t5_stall", stall_o, 0);
    checkOutput("t5_rdata", rdata_o, {RF_B, RF_A});

    // T6: hold freezes a stall, flush clears it and drops the issue
    applyStimulus(1, 1, 0, 5'd8, 5'd0, 5'd7, 2'b10);
    checkOutput("t6_stall", stall_o, 1);
    hold_i = 1'b1;
    repeat (3) cycle();
    checkOutput("t6_hold_stall", stall_o, 1);
    checkOutput("t6_hold_cnt", stall_cnt_o, 1);
    hold_i = 1'b0;
    flush_i = 1'b1;
    applyStimulus(1, 1, 0, 5'd7, 5'd0, 5'd7, 2'b10);
    cycle();
    flush_i = 1'b0;
    applyStimulus(0, 0, 0, 5'd0, 5'd0, 5'd7, 2'b10);
    checkOutput("t6_flush_stall", stall_o, 0);
    checkOutput("t6_flush_hit", fwd_hit_o, 2'b00);
    checkOutput("t6_flush_p1", rdata_o[63:32], RF_B);
    checkOutput("t6_flush_cnt", stall_cnt_o, 1);

    // Second load-use stall, then reset clears the counter
    applyStimulus(1, 1, 1, 5'd7, 5'd0, 5'd0, 2'b00);
    cycle();
    applyStimulus(0, 0, 0, 5'd0, 5'd7, 5'd0, 2'b01);
    checkOutput("t7_stall", stall_o, 1);
    cycle();
    checkOutput("t7_p0", rdata_o[31:0], 32'hC2C2_C2C2);
    checkOutput("t7_cnt", stall_cnt_o, 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    checkOutput("t7_rst_cnt", stall_cnt_o, 0);
    checkOutput("t7_rst_hit", fwd_hit_o, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
